// File: rtl/ram_arbiter.sv
// Two-master single-port RAM arbiter.
// m0 (CPU) and m1 (DMA/loader) share one RAM port. Arbitration is
// combinational, so a lone requester is granted in the same cycle.
// Ties are broken round-robin. A master can hold the port with its lock
// input, but only for MAX_HOLD consecutive grants.
//
// Handshake: mX_req is a single-cycle request. mX_gnt high in the same
// cycle means the access was issued to the RAM in that cycle. A master
// that is not granted keeps req high and retries. For a granted read,
// mX_rvalid pulses exactly one cycle later, and mX_rdata is valid in that
// same cycle.
module ram_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_HOLD   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic                  m0_lock,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic                  m1_lock,
   output logic                  m0_gnt,
   output logic                  m1_gnt,
   output logic                  m0_rvalid,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  ram_re,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } own_state_t;

   own_state_t state_q, state_d;
   logic       last_grant_q, last_grant_d;   // 0 = m0 granted last, 1 = m1
   logic [7:0] hold_q, hold_d;
   logic       rd_valid_q, rd_valid_d;
   logic       rd_id_q, rd_id_d;

   logic       gnt0, gnt1, any_gnt, sel_we, sel_lock, limit;
   logic [8:0] hold_inc;

   // Pick at most one master. An owner wins while it keeps requesting;
   // otherwise a lone requester wins, and a tie goes to the master that
   // was not granted last.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (state_q == OWN0 && m0_req) begin
            gnt0 = 1'b1;
         end else if (state_q == OWN1 && m1_req) begin
            gnt1 = 1'b1;
         end else if (m0_req && m1_req) begin
            if (last_grant_q) gnt0 = 1'b1;
            else              gnt1 = 1'b1;
         end else if (m0_req) begin
            gnt0 = 1'b1;
         end else if (m1_req) begin
            gnt1 = 1'b1;
         end
      end
   end

   // Mux the winner onto the RAM port; drive zeros when idle.
   always_comb begin
      any_gnt   = gnt0 | gnt1;
      sel_we    = 1'b0;
      sel_lock  = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (gnt0) begin
         sel_we    = m0_we;
         sel_lock  = m0_lock;
         ram_addr  = m0_addr;
         ram_wdata = m0_wdata;
      end else if (gnt1) begin
         sel_we    = m1_we;
         sel_lock  = m1_lock;
         ram_addr  = m1_addr;
         ram_wdata = m1_wdata;
      end
      ram_we = any_gnt & sel_we;
      ram_re = any_gnt & ~sel_we;
      m0_gnt = gnt0;
      m1_gnt = gnt1;
   end

   // Owner FSM and hold counter.
   // The hold count includes the grant that entered ownership. Ownership
   // is dropped on the grant that reaches MAX_HOLD, so that master is
   // then last_grant and loses the next tie.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      hold_inc = {1'b0, hold_q} + 9'd1;
      limit    = (hold_inc >= 9'(MAX_HOLD));
      case (state_q)
         IDLE: begin
            if (any_gnt && sel_lock && !limit) begin
               state_d = gnt0 ? OWN0 : OWN1;
               hold_d  = hold_inc[7:0];
            end
         end
         OWN0: begin
            if (gnt0 && m0_lock && !limit) begin
               hold_d = hold_inc[7:0];
            end else begin
               state_d = IDLE;
               hold_d  = 8'd0;
            end
         end
         OWN1: begin
            if (gnt1 && m1_lock && !limit) begin
               hold_d = hold_inc[7:0];
            end else begin
               state_d = IDLE;
               hold_d  = 8'd0;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = 8'd0;
         end
      endcase
   end

   // Round-robin history and read-tag next values.
   always_comb begin
      last_grant_d = any_gnt ? gnt1 : last_grant_q;
      rd_valid_d   = any_gnt & ~sel_we;
      rd_id_d      = gnt1;
   end

   // State registers. The reset makes m0 win the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         hold_q       <= 8'd0;
         rd_valid_q   <= 1'b0;
         rd_id_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         hold_q       <= hold_d;
         rd_valid_q   <= rd_valid_d;
         rd_id_q      <= rd_id_d;
      end
   end

   // Read return. The RAM data is shared, and the tag selects the owner
   // of the data.
   always_comb begin
      m0_rvalid = rd_valid_q & ~rd_id_q & ~rst;
      m1_rvalid = rd_valid_q &  rd_id_q & ~rst;
      m0_rdata  = ram_rdata;
      m1_rdata  = ram_rdata;
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM. The RAM
// loads the pattern 16'hA000 | addr[7:0] while rst is high.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic        ram_re, ram_we;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int fails   = 0;

  logic [15:0] mem [0:255];
  logic [5:0]  exp_m1_seq;

  ram_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // RAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
      ram_rdata <= 16'h0000;
    end else begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  initial begin
    // reset: a request while in reset must not be granted
    rst = 1;
    idle_inputs();
    m0_req = 1; m0_addr = 16'h0010;
    #2;
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    check("rst_state", dbg_state, 0);
    tick(); tick();
    rst = 0;
    idle_inputs();

    // lone m0 read of 0x0010
    m0_req = 1; m0_addr = 16'h0010;
    #2;
    check("rd_m0_gnt", m0_gnt, 1);
    check("rd_m1_gnt", m1_gnt, 0);
    check("rd_ram_re", ram_re, 1);
    check("rd_ram_we", ram_we, 0);
    check("rd_ram_addr", ram_addr, 16'h0010);
    tick();
    idle_inputs();
    #2;
    check("rd_m0_rvalid", m0_rvalid, 1);
    check("rd_m0_rdata", m0_rdata, 16'hA010);
    check("rd_m1_rvalid", m1_rvalid, 0);
    check("idle_gnt", {m0_gnt, m1_gnt}, 0);
    check("idle_ram_addr", ram_addr, 16'h0000);
    tick();
    #2;
    check("rd_rvalid_once", m0_rvalid, 0);

    // both request continuously from reset: m0,m1,m0,m1, reads back-to-back
    rst = 1; tick(); rst = 0;
    m0_req = 1; m0_addr = 16'h0040;
    m1_req = 1; m1_addr = 16'h0080;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("rr_m0_gnt", m0_gnt, (k % 2 == 0));
      check("rr_m1_gnt", m1_gnt, (k % 2 == 1));
      if (k > 0) begin
        check("rr_m0_rvalid", m0_rvalid, (k % 2 == 1));
        check("rr_m1_rvalid", m1_rvalid, (k % 2 == 0));
        check("rr_rdata", ram_rdata, (k % 2 == 1) ? 16'hA040 : 16'hA080);
      end
      tick();
    end
    idle_inputs();
    #2;
    check("rr_last_rvalid", m1_rvalid, 1);
    check("rr_last_rdata", m1_rdata, 16'hA080);
    tick();

    // m1 locked, MAX_HOLD=4: m1 x4, then m0 once, then m1 again
    rst = 1; tick(); rst = 0;
    m1_req = 1; m1_lock = 1; m1_addr = 16'h0080;
    #2;
    check("lk_first_m1_gnt", m1_gnt, 1);
    tick();
    check("lk_state_own1", dbg_state, 2);
    m0_req = 1; m0_addr = 16'h0040;
    exp_m1_seq = 6'b101111;
    for (int k = 1; k < 6; k++) begin
      #2;
      check("lk_m1_gnt", m1_gnt, exp_m1_seq[k]);
      check("lk_m0_gnt", m0_gnt, !exp_m1_seq[k]);
      check("lk_state", dbg_state, (k <= 3) ? 2 : 0);
      tick();
    end
    idle_inputs();
    tick();
    #2;
    check("lk_release_state", dbg_state, 0);

    // m0 writes 0xBEEF to 0x0020, then m1 reads it back
    m0_req = 1; m0_we = 1; m0_addr = 16'h0020; m0_wdata = 16'hBEEF;
    #2;
    check("wr_m0_gnt", m0_gnt, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_re", ram_re, 0);
    check("wr_ram_addr", ram_addr, 16'h0020);
    check("wr_ram_wdata", ram_wdata, 16'hBEEF);
    tick();
    idle_inputs();
    m1_req = 1; m1_addr = 16'h0020;
    #2;
    check("wr_m1_gnt", m1_gnt, 1);
    check("wr_m1_ram_re", ram_re, 1);
    check("wr_no_m0_rvalid", m0_rvalid, 0);
    tick();
    idle_inputs();
    #2;
    check("wr_m1_rvalid", m1_rvalid, 1);
    check("wr_m1_rdata", m1_rdata, 16'hBEEF);
    check("wr_m0_rvalid_never", m0_rvalid, 0);
    tick();

    // a write does not block the previous cycle's read return
    m0_req = 1; m0_addr = 16'h0010;
    tick();
    idle_inputs();
    m1_req = 1; m1_we = 1; m1_addr = 16'h0030; m1_wdata = 16'h1234;
    #2;
    check("wb_m0_rvalid", m0_rvalid, 1);
    check("wb_m0_rdata", m0_rdata, 16'hA010);
    check("wb_m1_gnt", m1_gnt, 1);
    check("wb_ram_we", ram_we, 1);
    tick();
    idle_inputs();
    #2;
    check("wb_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
    tick();

    // reset in the cycle after a read grant: no rvalid, next tie goes to m0
    m1_req = 1; m1_addr = 16'h0040;
    #2;
    check("mr_m1_gnt", m1_gnt, 1);
    tick();
    idle_inputs();
    rst = 1;
    #1;
    check("mr_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
    tick();
    rst = 0;
    m0_req = 1; m0_addr = 16'h0010;
    m1_req = 1; m1_addr = 16'h0080;
    #2;
    check("mr_tie_m0", m0_gnt, 1);
    check("mr_tie_m1", m1_gnt, 0);
    check("mr_post_rvalid", {m0_rvalid, m1_rvalid}, 0);
    tick();

    // lock without a request is no request
    idle_inputs();
    tick();
    m0_lock = 1; m1_lock = 1;
    #2;
    check("lnr_gnt", {m0_gnt, m1_gnt}, 0);
    check("lnr_ram_en", {ram_re, ram_we}, 0);
    tick();
    #2;
    check("lnr_state", dbg_state, 0);
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
